// File: rtl/conv_window_2x2_pkg.sv
// Shared constants and types for the 2x2 window feeder.
// Byte lanes match the convolution core's element (0,0)..(1,1) order.
package conv_window_2x2_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned WIN_W = 32;

  localparam int unsigned W00 = 3;
  localparam int unsigned W01 = 2;
  localparam int unsigned W10 = 1;
  localparam int unsigned W11 = 0;

  localparam logic [WIN_W-1:0] WIN_DATA_RST  = 32'h0;
  localparam logic             WIN_VALID_RST = 1'b0;
  localparam logic             WIN_LAST_RST  = 1'b0;
  localparam logic [PIX_W-1:0] PIX_RST       = 8'h0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [PIX_W-1:0] p00;
    logic [PIX_W-1:0] p01;
    logic [PIX_W-1:0] p10;
    logic [PIX_W-1:0] p11;
  } win_t;

  // Place each window element into its core byte lane.
  function automatic logic [WIN_W-1:0] pack_win(input win_t w);
    logic [WIN_W-1:0] v;
    v = '0;
    v[W00*PIX_W +: PIX_W] = w.p00;
    v[W01*PIX_W +: PIX_W] = w.p01;
    v[W10*PIX_W +: PIX_W] = w.p10;
    v[W11*PIX_W +: PIX_W] = w.p11;
    return v;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One-row line buffer: combinational read, registered write at the same address.
// Contents are not reset; every entry is written during row 0 before it is used.
module conv_line_buf #(
  parameter  int unsigned IMG_W = 8,
  parameter  int unsigned PIX_W = 8,
  localparam int unsigned AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             wr_en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  logic [PIX_W-1:0] mem_q [IMG_W];

  assign dout = mem_q[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= din;
    end
  end

endmodule

// File: rtl/conv_window_2x2.sv
// Raster pixel stream to stride-1 2x2 windows with valid/ready on both sides.
// Row/column counters, frame FSM and the window output register live here.
module conv_window_2x2
  import conv_window_2x2_pkg::*;
#(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [WIN_W-1:0] win_data,
  output logic             win_valid,
  input  logic             win_ready,
  output logic             win_last,
  output logic             busy
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PIX_W-1:0] above_prev_q, above_prev_d;
  logic [PIX_W-1:0] cur_prev_q, cur_prev_d;
  logic [WIN_W-1:0] win_data_q, win_data_d;
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;

  logic [PIX_W-1:0] above;
  logic             accept;
  logic             col_end;
  logic             last_pix;
  win_t             win_nxt;

  // Stall the input whenever a window is waiting and will not leave this cycle.
  assign pix_ready = !clear && (!win_valid_q || win_ready);
  assign accept    = pix_valid && pix_ready;
  assign col_end   = (col_q == CW'(IMG_W - 1));
  assign last_pix  = col_end && (row_q == RW'(IMG_H - 1));

  conv_line_buf #(
    .IMG_W(IMG_W),
    .PIX_W(PIX_W)
  ) u_line_buf (
    .clk  (clk),
    .addr (col_q),
    .wr_en(accept),
    .din  (pix_data),
    .dout (above)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    above_prev_d = above_prev_q;
    cur_prev_d   = cur_prev_q;
    win_data_d   = win_data_q;
    win_valid_d  = win_valid_q;
    win_last_d   = win_last_q;
    win_nxt      = '{p00: above_prev_q, p01: above, p10: cur_prev_q, p11: pix_data};

    if (clear) begin
      state_d     = ST_IDLE;
      col_d       = '0;
      row_d       = '0;
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end else begin
      if (win_ready) begin
        win_valid_d = 1'b0;
        win_last_d  = 1'b0;
      end
      if (accept) begin
        above_prev_d = above;
        cur_prev_d   = pix_data;
        state_d      = last_pix ? ST_IDLE : ST_RUN;
        if (col_end) begin
          col_d = '0;
          row_d = last_pix ? '0 : row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
        // Column 0 and row 0 have no complete 2x2 neighbourhood yet.
        if ((row_q != '0) && (col_q != '0)) begin
          win_data_d  = pack_win(win_nxt);
          win_valid_d = 1'b1;
          win_last_d  = last_pix;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      above_prev_q <= PIX_RST;
      cur_prev_q   <= PIX_RST;
      win_data_q   <= WIN_DATA_RST;
      win_valid_q  <= WIN_VALID_RST;
      win_last_q   <= WIN_LAST_RST;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      above_prev_q <= above_prev_d;
      cur_prev_q   <= cur_prev_d;
      win_data_q   <= win_data_d;
      win_valid_q  <= win_valid_d;
      win_last_q   <= win_last_d;
    end
  end

  assign win_data  = win_data_q;
  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;
  assign busy      = (state_q == ST_RUN);

endmodule
